// File: rtl/demux_1x4_32bits_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x4_32bits_reg_if
// Description : Bus bundle for the 1-to-4 registered demultiplexer. It carries
//               the producer-side word/select/valid/ready handshake, the four
//               registered channel outputs with their valid/ready pairs, and
//               the accepted-transfer counter.
//               Modports:
//                 slave  - the demultiplexer itself
//                 master - the environment (producer plus the four consumers)
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1x4_32bits_reg_if #(
    parameter int COUNT_W = 16
);
    logic [31:0]        in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        out0;
    logic [31:0]        out1;
    logic [31:0]        out2;
    logic [31:0]        out3;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [COUNT_W-1:0] accept_count;

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out0, out1, out2, out3, out_valid, accept_count
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out0, out1, out2, out3, out_valid, accept_count
    );
endinterface
`default_nettype wire

// File: rtl/demux_1x4_32bits_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x4_32bits_reg
// Description : Routes a 32-bit word to one of four channels, each backed by
//               a single holding register (data + valid). A word is accepted
//               when in_valid && in_ready; in_ready looks only at the selected
//               channel, so a stalled consumer never blocks traffic headed
//               elsewhere. A full channel whose consumer drains in the same
//               cycle can take a new word with no bubble. A counter tracks the
//               number of accepted words, wrapping modulo 2^COUNT_W.
// Ports       : CLK   - clock, rising edge
//               RESET - synchronous active-high reset
//               bus   - demux_1x4_32bits_reg_if.slave (in_data, in_sel,
//                       in_valid, in_ready, out0..out3, out_valid,
//                       out_ready, accept_count)
//               COUNT_W must match the COUNT_W of the connected interface.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x4_32bits_reg #(
    parameter int COUNT_W = 16
) (
    input  wire logic               CLK,
    input  wire logic               RESET,
    demux_1x4_32bits_reg_if.slave   bus
);

    localparam int c_NUM_CH = 4;

    logic [c_NUM_CH-1:0][31:0] r_data_q;
    logic [c_NUM_CH-1:0][31:0] w_data_d;
    logic [c_NUM_CH-1:0]       r_valid_q;
    logic [c_NUM_CH-1:0]       w_valid_d;
    logic [COUNT_W-1:0]        r_count_q;
    logic [COUNT_W-1:0]        w_count_d;

    logic w_in_ready;
    logic w_accept;

    // Ready only depends on the addressed channel: it can take a word if it is
    // empty or if its current word is leaving on this same edge.
    assign w_in_ready = !RESET && (!r_valid_q[bus.in_sel] || bus.out_ready[bus.in_sel]);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_data_d  = r_data_q;
        // Drain clears valid; out_ready on an empty channel is harmless since
        // the bit is already 0. Data is left untouched on drain.
        w_valid_d = r_valid_q & ~bus.out_ready;
        w_count_d = r_count_q;
        if (w_accept) begin
            // A same-cycle accept overrides the drain clear above.
            w_data_d[bus.in_sel]  = bus.in_data;
            w_valid_d[bus.in_sel] = 1'b1;
            w_count_d             = r_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data_q  <= '0;
            r_valid_q <= '0;
            r_count_q <= '0;
        end else begin
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_count_q <= w_count_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out0         = r_data_q[0];
    assign bus.out1         = r_data_q[1];
    assign bus.out2         = r_data_q[2];
    assign bus.out3         = r_data_q[3];
    assign bus.out_valid    = r_valid_q;
    assign bus.accept_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4_32bits_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x4_32bits_reg
// Description : Self-checking bench for demux_1x4_32bits_reg (COUNT_W = 4).
//               Directed vectors with hand-derived expectations, hand-written
//               multi-cycle sequences (counter wrap, mid-operation reset), and
//               random traffic. Every cycle is also checked against a
//               reference model holding one slot per channel plus a per-channel
//               queue of accepted words that delivered words must match.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x4_32bits_reg;

    localparam int c_CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    demux_1x4_32bits_reg_if #(.COUNT_W(c_CW)) bus ();

    demux_1x4_32bits_reg #(.COUNT_W(c_CW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        bit          rst;
        bit          vld;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  rdy;
        bit          exp_ir;    // in_ready before the edge
        logic [3:0]  exp_ov;    // out_valid after the edge
        logic [1:0]  ch;        // channel whose data is checked after the edge
        logic [31:0] exp_dat;
        logic [3:0]  exp_cnt;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model
    logic [31:0] m_dat [4];
    bit          m_vld [4];
    int          m_cnt;
    logic [31:0] m_q   [4][$];
    bit          m_ir;

    function automatic vec_t mk(bit r, bit v, logic [1:0] s, logic [31:0] d, logic [3:0] rd,
                                bit ir, logic [3:0] ov, logic [1:0] ch, logic [31:0] dat,
                                logic [3:0] cnt);
        vec_t x;
        x.rst = r; x.vld = v; x.sel = s; x.data = d; x.rdy = rd;
        x.exp_ir = ir; x.exp_ov = ov; x.ch = ch; x.exp_dat = dat; x.exp_cnt = cnt;
        return x;
    endfunction

    function automatic logic [31:0] get_out(int k);
        case (k)
            0:       return bus.out0;
            1:       return bus.out1;
            2:       return bus.out2;
            default: return bus.out3;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit v, logic [1:0] s, logic [31:0] d, logic [3:0] rd);
        rst          = r;
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.out_ready = rd;
    endtask

    // Before the edge: ready rule and delivery order against the queues.
    task automatic pre_edge();
        m_ir = !rst && (!m_vld[bus.in_sel] || bus.out_ready[bus.in_sel]);
        check("model_in_ready", {31'b0, bus.in_ready}, {31'b0, m_ir});
        for (int k = 0; k < 4; k++) begin
            if (m_vld[k] && bus.out_ready[k]) begin
                if (m_q[k].size() == 0) begin
                    check($sformatf("deliver_ch%0d_queue_empty", k), 32'd1, 32'd0);
                end else begin
                    check($sformatf("deliver_ch%0d", k), get_out(k), m_q[k].pop_front());
                end
            end
        end
    endtask

    // At the edge: advance the model using the values that were sampled.
    task automatic update_model();
        bit acc;
        acc = bus.in_valid && m_ir;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_dat[k] = 32'h0;
                m_vld[k] = 1'b0;
                m_q[k].delete();
            end
            m_cnt = 0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (m_vld[k] && bus.out_ready[k]) m_vld[k] = 1'b0;
            if (acc) begin
                m_dat[bus.in_sel] = bus.in_data;
                m_vld[bus.in_sel] = 1'b1;
                m_q[bus.in_sel].push_back(bus.in_data);
                m_cnt = (m_cnt + 1) % (1 << c_CW);
            end
        end
    endtask

    task automatic post_edge();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("model_out_valid%0d", k), {31'b0, bus.out_valid[k]}, {31'b0, m_vld[k]});
            check($sformatf("model_out%0d", k), get_out(k), m_dat[k]);
        end
        check("model_accept_count", {28'b0, bus.accept_count}, m_cnt);
    endtask

    // One cycle: inputs set at posedge+1, ready sampled at posedge+3,
    // outputs sampled at the following posedge+1.
    task automatic cycle();
        #2;
        pre_edge();
        @(posedge clk);
        update_model();
        #1;
        post_edge();
    endtask

    task automatic apply(vec_t v, string tag);
        drive(v.rst, v.vld, v.sel, v.data, v.rdy);
        #2;
        check({tag, "_in_ready"}, {31'b0, bus.in_ready}, {31'b0, v.exp_ir});
        pre_edge();
        @(posedge clk);
        update_model();
        #1;
        post_edge();
        check({tag, "_out_valid"}, {28'b0, bus.out_valid}, {28'b0, v.exp_ov});
        check({tag, "_out_data"}, get_out(int'(v.ch)), v.exp_dat);
        check({tag, "_accept_count"}, {28'b0, bus.accept_count}, {28'b0, v.exp_cnt});
    endtask

    vec_t vecs[11];

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_dat[k] = 32'h0;
            m_vld[k] = 1'b0;
        end
        m_cnt = 0;

        //          rst vld sel  data          rdy      ir ov       ch  dat            cnt
        vecs[0]  = mk(1, 1, 2'd2, 32'hFFFF_FFFF, 4'b0000, 0, 4'b0000, 0, 32'h0,         4'd0);
        vecs[1]  = mk(1, 1, 2'd2, 32'hFFFF_FFFF, 4'b0000, 0, 4'b0000, 2, 32'h0,         4'd0);
        vecs[2]  = mk(0, 1, 2'd2, 32'hA5A5_0001, 4'b1111, 1, 4'b0100, 2, 32'hA5A5_0001, 4'd1);
        vecs[3]  = mk(0, 0, 2'd0, 32'h0,         4'b1111, 1, 4'b0000, 2, 32'hA5A5_0001, 4'd1);
        vecs[4]  = mk(0, 1, 2'd1, 32'h11,        4'b1101, 1, 4'b0010, 1, 32'h11,        4'd2);
        vecs[5]  = mk(0, 1, 2'd1, 32'h22,        4'b1101, 0, 4'b0010, 1, 32'h11,        4'd2);
        vecs[6]  = mk(0, 1, 2'd3, 32'h33,        4'b0101, 1, 4'b1010, 3, 32'h33,        4'd3);
        vecs[7]  = mk(0, 0, 2'd0, 32'h0,         4'b1111, 1, 4'b0000, 1, 32'h11,        4'd3);
        vecs[8]  = mk(0, 1, 2'd0, 32'hDEAD,      4'b0000, 1, 4'b0001, 0, 32'hDEAD,      4'd4);
        vecs[9]  = mk(0, 1, 2'd0, 32'hBEEF,      4'b0001, 1, 4'b0001, 0, 32'hBEEF,      4'd5);
        vecs[10] = mk(0, 0, 2'd0, 32'h0,         4'b1111, 1, 4'b0000, 0, 32'hBEEF,      4'd5);

        drive(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 4'b0000);
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Mid-operation reset: fill all four channels with consumers stalled.
        for (int k = 0; k < 4; k++) begin
            apply(mk(0, 1, 2'(k), 32'h100 + k, 4'b0000, 1, 4'((1 << (k + 1)) - 1),
                     2'(k), 32'h100 + k, 4'(6 + k)), $sformatf("fill%0d", k));
        end
        apply(mk(1, 1, 2'd1, 32'hCAFE, 4'b0000, 0, 4'b0000, 3, 32'h0, 4'd0), "midreset");
        apply(mk(0, 1, 2'd3, 32'h7,    4'b0000, 1, 4'b1000, 3, 32'h7, 4'd1), "post_reset");

        // Counter wrap: 17 accepts after a reset leave the 4-bit counter at 1.
        apply(mk(1, 0, 2'd0, 32'h0, 4'b1111, 0, 4'b0000, 0, 32'h0, 4'd0), "wrap_reset");
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 2'(i), 32'h5000 + i, 4'b1111);
            cycle();
        end
        check("wrap_accept_count", {28'b0, bus.accept_count}, 32'd1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
            cycle();
        end

        // Drain everything and confirm no word remains undelivered.
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        cycle();
        for (int k = 0; k < 4; k++)
            check($sformatf("final_queue%0d_empty", k), m_q[k].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_1x4_32bits_reg.md
DEMUX_1X4_32BITS_REG -- requirements
Module: demux_1x4_32bits_reg

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter: COUNT_W, default 16, width of the accepted-transfer counter.
REQ-003 Port: CLK  input  1  clock; all state updates on the rising edge.
REQ-004 Port: RESET  input  1  synchronous active-high reset.
REQ-005 Port: in_data  input  32  word to route.
REQ-006 Port: in_sel  input  2  destination channel 0..3.
REQ-007 Port: in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts the word this cycle; combinational.
REQ-009 Port: out0, out1, out2, out3  output  32 each  registered channel data.
REQ-010 Port: out_valid  output  4  bit k set means outk holds an undelivered word.
REQ-011 Port: out_ready  input  4  bit k set means the channel k consumer takes outk this cycle.
REQ-012 Port: accept_count  output  COUNT_W  number of accepted input words, modulo 2^COUNT_W.

Function
REQ-013 Each channel k SHALL have one holding register, consisting of data_k (32 bits) and valid_k (out_valid[k]).
REQ-014 Accept SHALL mean in_valid && in_ready at a rising CLK edge.
REQ-015 Drain of channel k SHALL mean out_valid[k] && out_ready[k] at a rising CLK edge.
REQ-016 in_ready SHALL equal !RESET && (!out_valid[in_sel] || out_ready[in_sel]).
REQ-017 in_ready SHALL depend only on the selected channel, so a stalled channel never blocks a word routed to a free channel.
REQ-018 On accept, data_k for k = in_sel SHALL load in_data and valid_k SHALL be set at that edge, giving one-cycle latency from accept to out_valid[k].
REQ-019 On a drain of channel k with no accept to k, valid_k SHALL clear at the edge and data_k SHALL hold its value.
REQ-020 On a simultaneous drain and accept for the same channel, data_k SHALL load the new word and valid_k SHALL stay 1, with no bubble.
REQ-021 While out_valid[k] && !out_ready[k], outk SHALL remain stable.
REQ-022 Words for the same channel SHALL be delivered in accept order, and no word SHALL be dropped or duplicated.
REQ-023 Channels not selected by an accept SHALL change only by their own drain.
REQ-024 When in_valid is 0, in_sel and in_data SHALL be ignored and no channel SHALL be written.
REQ-025 accept_count SHALL increment by 1 on each accept and wrap from 2^COUNT_W-1 to 0.
REQ-026 out_ready[k] asserted while out_valid[k] is 0 SHALL have no effect.
REQ-027 All outputs except in_ready SHALL be driven directly from registers.

Reset
REQ-028 While RESET=1 at an edge, the block SHALL set out0..out3 to 32'h0, out_valid to 4'b0000, and accept_count to 0.
REQ-029 While RESET=1, in_ready SHALL be 0 and no accept SHALL occur.
REQ-030 A reset arriving mid-operation SHALL discard all pending words without delivery, and the block SHALL accept again on the first cycle after RESET deasserts.

Verification
REQ-031 Reset check: assert RESET for 2 cycles with in_valid=1 -> out_valid=0000, out0..3=0, accept_count=0, in_ready=0 throughout.
REQ-032 Basic routing: send 32'hA5A5_0001 with sel=2 while out_ready=1111 -> out2=32'hA5A5_0001 and out_valid=0100 one cycle later, then 0000 the next cycle; accept_count=1.
REQ-033 Stall isolation: with out_ready[1]=0, send 32'h11 then 32'h22 to ch1, then 32'h33 to ch3 -> second ch1 word sees in_ready=0 and out1 stays 32'h11; after moving to ch3, in_ready=1 and out3=32'h33.
REQ-034 Back-to-back same channel: ch0 full with 32'hDEAD, out_ready[0]=1, send 32'hBEEF to ch0 -> in_ready=1, out0=32'hBEEF next cycle, out_valid[0] stays 1.
REQ-035 Counter wrap: with COUNT_W=4, perform 17 accepts -> accept_count reads 1.
REQ-036 Reset mid-operation: all four channels valid and out_ready=0000, pulse RESET for 1 cycle -> out_valid=0000 and all outputs 0; the next accept of 32'h7 to ch3 appears on out3 one cycle later.
